// File: rtl/score_update_controller_if.sv
// Move-engine / display-side bundle for the score update controller.
// The producer drives map offers and new_game; the controller returns score state.
interface score_update_controller_if #(
  parameter int SCORE_W   = 24,
  parameter int NUM_CELLS = 16
);

  logic                   req_valid;
  logic                   req_ready;
  logic [4*NUM_CELLS-1:0] merge_map;
  logic                   new_game;
  logic [SCORE_W-1:0]     score;
  logic [SCORE_W-1:0]     best_score;
  logic                   score_updated;
  logic                   busy;

  modport master (
    output req_valid,
    output merge_map,
    output new_game,
    input  req_ready,
    input  score,
    input  best_score,
    input  score_updated,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  merge_map,
    input  new_game,
    output req_ready,
    output score,
    output best_score,
    output score_updated,
    output busy
  );

endinterface

// File: rtl/score_update_controller.sv
// Serial 2048 score accumulator: scans one merge-map cell per cycle through a
// single saturating adder, then commits the running score and tracks the best.
module score_update_controller #(
  parameter int SCORE_W   = 24,
  parameter int NUM_CELLS = 16
) (
  input logic                      clk,
  input logic                      rst,
  score_update_controller_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CELLS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;

  logic [4*NUM_CELLS-1:0] r_map;
  logic [IDX_W-1:0]       r_idx;
  logic [SCORE_W-1:0]     r_acc;
  logic [SCORE_W-1:0]     r_score;
  logic [SCORE_W-1:0]     r_best;
  logic                   r_updated;

  logic [3:0]             w_cell;
  logic [SCORE_W-1:0]     w_addend;
  logic [SCORE_W:0]       w_sum;
  logic [SCORE_W-1:0]     w_satSum;
  logic                   w_lastCell;

  assign w_cell     = r_map[{r_idx, 2'b00} +: 4];
  assign w_addend   = (w_cell == 4'd0) ? '0 : (SCORE_W'(1) << w_cell);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_addend};
  // The extra sum bit is the overflow flag; clamp instead of wrapping.
  assign w_satSum   = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
  assign w_lastCell = (r_idx == IDX_W'(NUM_CELLS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_nextState = SCAN;
      SCAN:    if (w_lastCell)    w_nextState = COMMIT;
      COMMIT:                     w_nextState = IDLE;
      default:                    w_nextState = IDLE;
    endcase
    // A new game aborts everything, including a simultaneous accept.
    if (bus.new_game) begin
      w_nextState = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_map     <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_score   <= '0;
      r_best    <= '0;
      r_updated <= 1'b0;
    end else if (bus.new_game) begin
      r_idx     <= '0;
      r_acc     <= '0;
      r_score   <= '0;
      r_updated <= 1'b0;
    end else begin
      r_updated <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_map <= bus.merge_map;
            r_acc <= r_score;
            r_idx <= '0;
          end
        end
        SCAN: begin
          if (w_cell != 4'd0) begin
            r_acc <= w_satSum;
          end
          r_idx <= r_idx + IDX_W'(1);
        end
        COMMIT: begin
          r_score   <= r_acc;
          r_updated <= 1'b1;
          if (r_acc > r_best) begin
            r_best <= r_acc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready     = (r_state == IDLE);
  assign bus.busy          = (r_state != IDLE);
  assign bus.score         = r_score;
  assign bus.best_score    = r_best;
  assign bus.score_updated = r_updated;

endmodule

// File: tb/tb_score_update_controller.sv
// Directed bench for score_update_controller with hand-computed expected scores.
module tb_score_update_controller;

  localparam int SCORE_W   = 24;
  localparam int NUM_CELLS = 16;
  localparam logic [63:0] ALL_F = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  score_update_controller_if #(.SCORE_W(SCORE_W), .NUM_CELLS(NUM_CELLS)) bus ();

  score_update_controller #(.SCORE_W(SCORE_W), .NUM_CELLS(NUM_CELLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Offer a map, wait (bounded) for acceptance, then scramble the bus.
  task automatic applyStimulus(input logic [63:0] map);
    int waitCnt;
    waitCnt = 0;
    bus.req_valid = 1'b1;
    bus.merge_map = map;
    while (!bus.req_ready && waitCnt < 100) begin
      tick();
      waitCnt++;
    end
    checkOutput("acceptReady", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    bus.merge_map = ALL_F;
    checkOutput("acceptBusy", bus.busy, 1);
  endtask

  // Called right after the accepting edge; ends one cycle past the commit pulse.
  task automatic waitCommit(input string tag, input int expScore, input int expBest);
    int lowCount;
    int pulses;
    lowCount = 0;
    pulses   = 0;
    while (!bus.req_ready && lowCount < 40) begin
      lowCount++;
      if (bus.score_updated) pulses++;
      tick();
    end
    checkOutput({tag, "_readyLow"}, lowCount, 17);
    checkOutput({tag, "_earlyPulse"}, pulses, 0);
    checkOutput({tag, "_pulse"}, bus.score_updated, 1);
    checkOutput({tag, "_score"}, bus.score, expScore);
    checkOutput({tag, "_best"}, bus.best_score, expBest);
    tick();
    checkOutput({tag, "_pulseEnd"}, bus.score_updated, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expScore;
    int pulses;
    int busyCycles;
    checkCount    = 0;
    failCount     = 0;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.merge_map = '0;
    bus.new_game  = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    checkOutput("rstScore", bus.score, 0);
    checkOutput("rstBest", bus.best_score, 0);
    checkOutput("rstPulse", bus.score_updated, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstReady", bus.req_ready, 1);

    applyStimulus(64'h1);
    waitCommit("cell0", 2, 2);

    applyStimulus(64'h1111_1111_1111_1111);
    waitCommit("allOnes", 34, 34);

    applyStimulus(64'h000F_0000_00B0_0000);
    waitCommit("bigTiles", 34850, 34850);

    // Map A (cell0=2 -> 4) accepted; map B (cell1=3 -> 8) held with valid high.
    bus.req_valid = 1'b1;
    bus.merge_map = 64'h2;
    tick();
    bus.merge_map = 64'h30;
    waitCommit("held1", 34854, 34854);
    checkOutput("heldAccept", bus.busy, 1);
    bus.req_valid = 1'b0;
    bus.merge_map = ALL_F;
    waitCommit("held2", 34862, 34862);

    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    checkOutput("ngIdleScore", bus.score, 0);
    checkOutput("ngIdleBest", bus.best_score, 34862);

    // Each all-F map adds 16 * 32768 = 524288; the 32nd crosses 2^24-1.
    for (int i = 1; i <= 32; i++) begin
      expScore = (i * 524288 > 16777215) ? 16777215 : i * 524288;
      applyStimulus(ALL_F);
      waitCommit($sformatf("sat%0d", i), expScore, expScore);
    end
    applyStimulus(64'h1);
    waitCommit("satHold", 16777215, 16777215);

    applyStimulus(64'h1);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("midRstScore", bus.score, 0);
    checkOutput("midRstBest", bus.best_score, 0);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstReady", bus.req_ready, 1);
    checkOutput("midRstPulse", bus.score_updated, 0);

    applyStimulus(64'h256);
    waitCommit("hundred", 100, 100);

    // Abort at the edge ending scan cycle 7.
    applyStimulus(64'h1);
    repeat (6) tick();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    checkOutput("abortScore", bus.score, 0);
    checkOutput("abortBest", bus.best_score, 100);
    checkOutput("abortPulse", bus.score_updated, 0);
    checkOutput("abortReady", bus.req_ready, 1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.score_updated) pulses++;
      tick();
    end
    checkOutput("abortNoCommit", pulses, 0);
    checkOutput("abortScoreHeld", bus.score, 0);

    applyStimulus(64'h3);
    waitCommit("eight", 8, 100);

    applyStimulus(64'hA);
    repeat (16) tick();
    checkOutput("commitStateBusy", bus.busy, 1);
    checkOutput("commitStateReady", bus.req_ready, 0);
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    checkOutput("ngCommitScore", bus.score, 0);
    checkOutput("ngCommitBest", bus.best_score, 100);
    checkOutput("ngCommitPulse", bus.score_updated, 0);
    checkOutput("ngCommitReady", bus.req_ready, 1);

    bus.req_valid = 1'b1;
    bus.merge_map = 64'hA;
    bus.new_game  = 1'b1;
    tick();
    bus.new_game  = 1'b0;
    bus.req_valid = 1'b0;
    checkOutput("ngAcceptBusy", bus.busy, 0);
    checkOutput("ngAcceptReady", bus.req_ready, 1);
    checkOutput("ngAcceptScore", bus.score, 0);
    busyCycles = 0;
    pulses     = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.busy) busyCycles++;
      if (bus.score_updated) pulses++;
      tick();
    end
    checkOutput("ngAcceptNoScan", busyCycles, 0);
    checkOutput("ngAcceptNoPulse", pulses, 0);
    checkOutput("ngAcceptBest", bus.best_score, 100);

    applyStimulus(64'h1);
    waitCommit("final", 2, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/score_update_controller.md
Name: score_update_controller

Overview:
- Sequences score accumulation for the 2048 board after each move.
- Accepts one 64-bit merge map per move: 16 cells × 4-bit exponent; non-zero exponent = tile of value 2^exp created by a merge in that cell.
- Scans the map serially, one cell per cycle, through a single shared adder, then commits the running score and tracks the best score.
- Sits between the move/merge engine (producer) and the BCD/display path (consumer of score and best_score).

Parameters:
- SCORE_W, 24, width of score, best_score and the internal accumulator.
- NUM_CELLS, 16, cells per merge map; fixed at 16 (map width = 4*NUM_CELLS).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- req_valid  input  1  merge map offered
- req_ready  output  1  controller can accept a map
- merge_map  input  64  cell i at bits [4i+3:4i]; 0 = no merge, 1..15 = merged exponent
- new_game  input  1  single-cycle pulse: clear score, abort any scan
- score  output  SCORE_W  committed current score (binary)
- best_score  output  SCORE_W  highest committed score since reset
- score_updated  output  1  one-cycle pulse after each commit
- busy  output  1  high in SCAN or COMMIT

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; score=0, best_score=0, score_updated=0, busy=0, req_ready=1 in the cycle after reset.
- States: IDLE, SCAN, COMMIT.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at edge E0: latch merge_map, acc<=score, idx<=0, go to SCAN.
- SCAN:
  - req_ready=0, busy=1.
  - At edges E1..E16: if cell[idx]!=0, acc<=sat(acc + (1<<cell[idx])); idx<=idx+1.
  - Always exactly 16 cycles; zero cells are not skipped.
  - At E16 go to COMMIT.
- COMMIT:
  - At E17: score<=acc; best_score<=max(best_score, acc); score_updated<=1 for the cycle following E17; go to IDLE.
  - req_ready=1 from the cycle after E17.
  - Back-to-back requests are therefore spaced 18 cycles apart.
- Arithmetic:
  - Per-cell addend is 1<<exp, zero-extended to SCORE_W (exp=15 gives 32768).
  - Accumulator saturates at 2^SCORE_W-1 and never wraps.
  - Once saturated, further adds hold at max.
- Handshake:
  - req_valid may be held across busy cycles; the map is sampled only at the accepting edge.
  - merge_map changes while busy are ignored.
  - Dropping req_valid before acceptance loses the request, which is legal.
- new_game:
  - At any edge: score<=0, acc<=0, state<=IDLE, score_updated<=0; best_score is retained.
  - Overrides a simultaneous accept: that request is not taken and req_valid must be re-presented.
  - Mid-SCAN: the scan is aborted and no commit occurs.
  - Coinciding with COMMIT edge E17: the clear wins; score=0 and best_score unchanged by that commit.
- busy: equals (state != IDLE); req_ready = (state == IDLE).
- Reset mid-operation: same as power-on reset, including best_score cleared.

Test Plan:
- Reset, then accept a map with only cell 0 = 1 -> score=2, best_score=2, score_updated pulses exactly once, 18 cycles after the accepting edge; req_ready low for 17 cycles.
- Map with every cell = 1, accepted with score=2 -> score=34; next map with cell 5 = 11 and cell 12 = 15 -> score=34+2048+32768=34850.
- Score preloaded near 2^24-1 via repeated exp-15 maps (SCORE_W=24) -> score saturates at 16777215 and stays there on further maps.
- req_valid held high across a running scan -> second map accepted on the first cycle req_ready returns, not earlier; both maps' values summed correctly.
- new_game asserted at scan cycle 7 with score=100 -> score=0 next cycle, no score_updated pulse, best_score=100, req_ready=1 next cycle.
- new_game coincident with the COMMIT edge, and separately with an accepting edge -> score=0, best_score unchanged, no commit, request not taken.
